// File: rtl/kanade_bus_pkg.sv
// Shared definitions for the kanade memory bus.
// Holds the responder state encoding and the bus field widths used by the
// interface, the responder and its storage array.
package kanade_bus_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int ADDR_W = 30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/kanade_mem_responder_if.sv
// Request/acknowledge memory bus between the core's memory initiator and the
// memory responder.
//   req/we/addr/wdata/be : request, driven by the initiator
//   rdata/ack/err/busy   : response, driven by the responder
// master modport = initiator side, slave modport = responder side.
interface kanade_mem_responder_if;
  import kanade_bus_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic [WORD_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack, err, busy
  );

endinterface

// File: rtl/kanade_sram_be.sv
// Synchronous single-port word array with byte-enabled writes.
//   clk   : rising-edge clock
//   en    : access enable; nothing happens on an edge without it
//   we    : 1 = write the enabled bytes, 0 = read only
//   addr  : word index
//   be    : byte enables, be[i] selects wdata[8i+7:8i]
//   wdata : write data
//   q     : registered read data (old contents on a write edge)
// No reset: the contents and q power up undefined.
module kanade_sram_be
  import kanade_bus_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [BE_W-1:0]   be,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] q
);

  logic [WORD_W-1:0] mem [2**AW];
  logic [WORD_W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
      q_q <= mem[addr];
    end
  end

  assign q = q_q;

endmodule

// File: rtl/kanade_mem_responder.sv
// Memory-side responder for the core's shared instruction/data port.
// Accepts one request at a time, waits WAIT_CYCLES states, then returns a
// one-cycle ack with read data, or with err=1 for an out-of-range address.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of the request/ack bus (req/we/addr/wdata/be in,
//             rdata/ack/err/busy out); all outputs are registered
module kanade_mem_responder
  import kanade_bus_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  kanade_mem_responder_if.slave  bus
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              rd_ok_q, rd_ok_d;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [WORD_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              in_range;
  logic              to_resp;
  logic              mem_en;
  logic [WORD_W-1:0] mem_rdata;

  // In IDLE the accepting edge may also be the edge entering RESP (zero wait
  // states), so the array sees the live request; otherwise the captured one.
  always_comb begin
    sel_we    = (state_q == ST_IDLE) ? bus.we    : we_q;
    sel_addr  = (state_q == ST_IDLE) ? bus.addr  : addr_q;
    sel_wdata = (state_q == ST_IDLE) ? bus.wdata : wdata_q;
    sel_be    = (state_q == ST_IDLE) ? bus.be    : be_q;
    in_range  = ({1'b0, sel_addr} < (31'd1 << DEPTH_LOG2));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          be_d    = bus.be;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The array is touched only on the edge entering RESP; reset_n gates it
    // so a request seen while held in reset can never commit a write.
    to_resp = (state_d == ST_RESP);
    mem_en  = to_resp && in_range && reset_n;
    ack_d   = to_resp;
    err_d   = to_resp && !in_range;
    busy_d  = (state_d != ST_IDLE);
    rd_ok_d = to_resp && !sel_we && in_range;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  kanade_sram_be #(
    .AW (DEPTH_LOG2)
  ) u_sram (
    .clk   (clk),
    .en    (mem_en),
    .we    (sel_we),
    .addr  (sel_addr[DEPTH_LOG2-1:0]),
    .be    (sel_be),
    .wdata (sel_wdata),
    .q     (mem_rdata)
  );

  // The array output is only meaningful for an in-range read ack.
  assign bus.rdata = rd_ok_q ? mem_rdata : '0;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule
